// File: rtl/mips_cpu_bus_initiator.sv
// CPU-side bus initiator: one load/store at a time, waitrequest-stalled strobes, lane-aligned extended load data.
// Optional MIPS_BUS_ALIGN_CHECK_EN rejects misaligned half/word accesses with rsp_err instead of force-aligning.
module mips_cpu_bus_initiator #(
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_WAITD, S_RESP} state_t;

    state_t      state_q, state_d;
    logic        write_q, signed_q, err_q;
    logic [1:0]  size_q, off_q, lat_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic [7:0]  wait_q;

    logic        req_fire, bad_d, accept, timed_out, sample;
    logic [1:0]  off_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, lane, load_ext;

    assign req_fire  = req_valid && (state_q == S_IDLE);
    assign accept    = (state_q == S_BUS) && !waitrequest;
    assign timed_out = (state_q == S_BUS) && waitrequest && (wait_q == 8'(TIMEOUT - 1));
    assign sample    = (state_q == S_WAITD) && (lat_q == 2'd1);

    // Decode the incoming request into its aligned lane offset, enables and shifted store data.
    always_comb begin
        off_d   = 2'b00;
        be_d    = 4'b0000;
        wdata_d = 32'h0;
        bad_d   = 1'b0;
        case (req_size)
            2'b00: begin
                off_d   = req_addr[1:0];
                be_d    = 4'b0001 << req_addr[1:0];
                wdata_d = {24'h0, req_wdata[7:0]} << {req_addr[1:0], 3'b000};
            end
            2'b01: begin
                off_d   = {req_addr[1], 1'b0};
                be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {16'h0, req_wdata[15:0]} << {req_addr[1], 4'b0000};
`ifdef MIPS_BUS_ALIGN_CHECK_EN
                bad_d   = req_addr[0];
`else
                bad_d   = 1'b0;
`endif
            end
            2'b10: begin
                be_d    = 4'b1111;
                wdata_d = req_wdata;
`ifdef MIPS_BUS_ALIGN_CHECK_EN
                bad_d   = |req_addr[1:0];
`else
                bad_d   = 1'b0;
`endif
            end
            default: bad_d = 1'b1;
        endcase
    end

    always_comb begin
        lane     = readdata >> {off_q, 3'b000};
        load_ext = lane;
        case (size_q)
            2'b00:   load_ext = {{24{signed_q & lane[7]}}, lane[7:0]};
            2'b01:   load_ext = {{16{signed_q & lane[15]}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_fire) state_d = bad_d ? S_RESP : S_BUS;
            S_BUS: begin
                if (accept)         state_d = write_q ? S_RESP : S_WAITD;
                else if (timed_out) state_d = S_RESP;
            end
            S_WAITD: if (sample) state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        read      = (state_q == S_BUS) && !write_q;
        write     = (state_q == S_BUS) && write_q;
        rsp_valid = (state_q == S_RESP);
        rsp_err   = (state_q == S_RESP) && err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= 2'b00;
            off_q    <= 2'b00;
            lat_q    <= 2'b00;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            be_q     <= 4'b0000;
            wait_q   <= 8'h0;
        end else begin
            if (req_fire) begin
                write_q  <= req_write;
                signed_q <= req_signed;
                size_q   <= req_size;
                off_q    <= off_d;
                addr_q   <= {req_addr[31:2], 2'b00};
                be_q     <= bad_d ? 4'b0000 : be_d;
                wdata_q  <= bad_d ? 32'h0 : wdata_d;
                err_q    <= bad_d;
                rdata_q  <= 32'h0;
                wait_q   <= 8'h0;
            end
            if (state_q == S_BUS && waitrequest) wait_q <= wait_q + 8'd1;
            if (timed_out)                       err_q  <= 1'b1;
            if (accept)                          lat_q  <= 2'(READ_LATENCY);
            if (state_q == S_WAITD)              lat_q  <= lat_q - 2'd1;
            if (sample)                          rdata_q <= load_ext;
        end
    end

    assign address    = addr_q;
    assign byteenable = be_q;
    assign writedata  = wdata_q;
    assign rsp_rdata  = rdata_q;

endmodule

// File: tb/tb_mips_cpu_bus_initiator.sv
// Randomized scoreboard bench for mips_cpu_bus_initiator with a byte-level reference model and a stalling responder.
module tb_mips_cpu_bus_initiator;
    localparam int RL = 2;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, rsp_valid, rsp_err, read, write;
    logic [31:0] rsp_rdata, address, writedata;
    logic [3:0]  byteenable;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata = 32'h0;

    always #5 clk = ~clk;

    mips_cpu_bus_initiator #(.READ_LATENCY(RL), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .address(address), .read(read), .write(write), .byteenable(byteenable),
        .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          strobes;
        int          busy;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        wr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [0:255];
    int          n_vec = 0;
    int          n_err = 0;
    int          stall_plan = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: bytes selected by size and force-aligned offset, assembled and extended byte by byte.
    function automatic exp_t model(input logic wr, input logic [1:0] size, input logic sgn,
                                   input logic [31:0] addr, input logic [31:0] wdata, input int stall);
        exp_t        e;
        int          n, off;
        logic        bad;
        logic [31:0] word, v;
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        bad = (size == 2'd3);
`ifdef MIPS_BUS_ALIGN_CHECK_EN
        if ((int'(addr[1:0]) % n) != 0) bad = 1'b1;
`endif
        off     = (int'(addr[1:0]) / n) * n;
        e.rdata = 32'h0; e.err = 1'b0; e.be = 4'h0; e.wd = 32'h0;
        e.addr  = {addr[31:2], 2'b00}; e.wr = wr;
        e.strobes = 0; e.busy = 1;
        if (bad) begin
            e.err = 1'b1;
            return e;
        end
        for (int i = 0; i < n; i++) begin
            e.be[off+i]          = 1'b1;
            e.wd[(off+i)*8 +: 8] = wdata[i*8 +: 8];
        end
        if (stall >= TO) begin
            e.err = 1'b1; e.strobes = TO; e.busy = TO + 1;
            return e;
        end
        e.strobes = stall + 1;
        e.busy    = e.strobes + 1 + (wr ? 0 : RL);
        if (!wr) begin
            word = mem[addr[9:2]];
            v    = 32'h0;
            for (int i = 0; i < n; i++) v[i*8 +: 8] = word[(off+i)*8 +: 8];
            if (sgn && n < 4 && v[n*8-1])
                for (int i = n; i < 4; i++) v[i*8 +: 8] = 8'hFF;
            e.rdata = v;
        end
        return e;
    endfunction

    task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input int stall);
        int guard = 0;
        while (!req_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            chk("req_ready_wait", {31'h0, req_ready}, 32'h1);
            return;
        end
        stall_plan = stall;
        sb.push_back(model(wr, size, sgn, addr, wdata, stall));
        req_valid = 1'b1; req_write = wr; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid  = 1'b0;
        req_write  = 1'($urandom_range(0, 1));
        req_size   = 2'($urandom_range(0, 3));
        req_signed = 1'($urandom_range(0, 1));
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_pending", 32'(sb.size()), 32'h0);
    endtask

    // Responder and response monitor, all sampled on the falling edge.
    logic        in_txn = 1'b0, unstable = 1'b0, f_wr = 1'b0;
    logic [31:0] f_addr = 32'h0, f_wd = 32'h0;
    logic [3:0]  f_be = 4'h0;
    int          stall_left = 0, strobe_cnt = 0, busy_cyc = 0, pend = -1;
    exp_t        e;

    always @(negedge clk) begin
        if (reset) begin
            in_txn = 1'b0; strobe_cnt = 0; busy_cyc = 0; pend = -1; waitrequest = 1'b0;
        end else begin
            if (!req_ready) busy_cyc++;
            chk("one_strobe", {31'h0, read & write}, 32'h0);
            if (pend > 0) pend--;
            if (pend == 0) begin
                readdata = mem[f_addr[9:2]];
                pend = -1;
            end else begin
                readdata = $urandom;
            end
            if (read || write) begin
                if (!in_txn) begin
                    in_txn = 1'b1; stall_left = stall_plan; unstable = 1'b0;
                    f_addr = address; f_be = byteenable; f_wd = writedata; f_wr = write;
                end else if (address !== f_addr || byteenable !== f_be ||
                             writedata !== f_wd || write !== f_wr) begin
                    unstable = 1'b1;
                end
                strobe_cnt++;
                if (stall_left > 0) begin
                    waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    waitrequest = 1'b0;
                    if (read) pend = RL;
                end
            end else begin
                in_txn = 1'b0;
                waitrequest = 1'($urandom_range(0, 1));
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", {31'h0, rsp_valid}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                    chk("strobe_cycles", 32'(strobe_cnt), 32'(e.strobes));
                    chk("busy_cycles", 32'(busy_cyc), 32'(e.busy));
                    if (e.strobes > 0) begin
                        chk("bus_address", f_addr, e.addr);
                        chk("bus_byteenable", {28'h0, f_be}, {28'h0, e.be});
                        chk("bus_is_write", {31'h0, f_wr}, {31'h0, e.wr});
                        chk("bus_stable", {31'h0, unstable}, 32'h0);
                        if (e.wr) chk("bus_writedata", f_wd, e.wd);
                    end
                end
                strobe_cnt = 0;
                busy_cyc = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] sz;
        int         st;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[64] = 32'hDEADBEEF;

        @(negedge clk);
        chk("rst_read", {31'h0, read}, 32'h0);
        chk("rst_write", {31'h0, write}, 32'h0);
        chk("rst_byteenable", {28'h0, byteenable}, 32'h0);
        chk("rst_address", address, 32'h0);
        chk("rst_writedata", writedata, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        reset = 1'b0;
        @(negedge clk);

        issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 0);
        drain();
        mem[64][31:24] = 8'h80;
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 0);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 1);
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 4);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 100);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0304, 32'h1234_5678, TO - 1);
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0305, 32'h0, TO);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 0);
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0101, 32'h0, 0);
        issue(1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 0);
        drain();

        stall_plan = 50;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h40;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_read", {31'h0, read}, 32'h0);
        chk("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("midrst_req_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0082, 32'h0, 0);
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0081, 32'h0000_00A5, 2);
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0081, 32'h0, 0);

        for (int i = 0; i < 200; i++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            st = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 1, TO + 2))
                                             : int'($urandom_range(0, 3));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom, $urandom, st);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
